ex_mdu: RTL and testbench
=========================

# ex_mdu

Parametrised execute stage for the in-order MIPS pipeline, sitting between the ID/EX and EX/MEM pipeline registers. It produces single-cycle results for logic, shift, move and add/sub/compare operations. It also contains an iterative signed/unsigned divider that stalls the pipeline until the HI/LO write is ready. Flush cancels an in-flight divide.

## Interface
Clock is `clk`; reset is `rst`, asynchronous and active-low.

Parameters:
- `DW`, 32: datapath width; power of two, ≥ 8.
- `AW`, 5: register-file address width.
- `SW`: not overridable, equal to $clog2(DW); shift-amount width.

Ports:
- `clk` in 1: pipeline clock.
- `rst` in 1: asynchronous active-low reset.
- `aluop_i` in 8: operation code.
- `alusel_i` in 3: result class.
- `reg1_i` in DW: operand 1; also the shift amount in its low SW bits.
- `reg2_i` in DW: operand 2; also the shift source.
- `wd_i` in AW: destination register address.
- `wreg_i` in 1: register write enable.
- `hi_i` in DW: current HI value, already forwarded.
- `lo_i` in DW: current LO value, already forwarded.
- `flush_i` in 1: cancel the current instruction.
- `wd_o` out AW: destination register address, passed through.
- `wreg_o` out 1: register write enable.
- `wdata_o` out DW: register write data.
- `whilo_o` out 1: HI/LO write enable.
- `hi_o` out DW: HI write data.
- `lo_o` out DW: LO write data.
- `stallreq_o` out 1: stall request to the pipeline controller.

## Operation
Opcodes (aluop_i):
- AND 00100100, OR 00100101, XOR 00100110, NOR 00100111.
- SLL 01111100, SRL 00000010, SRA 00000011.
- ADDU 00100001, SUBU 00100011, SLT 00101010, SLTU 00101011.
- MFHI 00010000, MFLO 00010010.
- DIV 00011010, DIVU 00011011.
- Unknown opcode → 0.

Result classes (alusel_i):
- NOP 000, LOGIC 001, SHIFT 010, MOVE 011, ARITH 100.
- wdata_o selects the class result; any other alusel_i → 0.

Combinational operations:
- Shifts act on reg2_i by reg1_i[SW-1:0]. SRA sign-fills.
- ADDU/SUBU are modulo 2^DW; no overflow trap.
- SLT compares signed, SLTU compares unsigned; result is 1 or 0, zero-extended.
- wd_o always equals wd_i. wreg_o equals wreg_i, except it is forced to 0 for DIV/DIVU.

Divider FSM, states IDLE, BUSY, DONE:
- IDLE → BUSY on DIV/DIVU with a nonzero divisor and flush_i=0. Operand magnitudes are latched (two's-complement absolute values for DIV), and the count is cleared.
- IDLE → DONE on DIV/DIVU with reg2_i == 0. Result: HI = reg1_i, LO = all ones.
- BUSY: one restoring shift-subtract step per cycle, count 0..DW-1. At count == DW-1 → DONE.
- DONE: final results are held in registers.
  - For DIV, the quotient is negated if operand signs differ, and the remainder takes the dividend's sign.
  - whilo_o=1, lo_o=quotient, hi_o=remainder.
  - Next state is IDLE.
- flush_i=1 in BUSY or DONE → IDLE next cycle, whilo_o forced 0 in that cycle.

Outputs by state:
- stallreq_o = 1 in IDLE while a divide is being issued, and throughout BUSY; 0 in DONE and otherwise.
- whilo_o = 0 outside DONE; hi_o/lo_o = 0 when whilo_o=0.
- Inputs are held stable by the pipeline while stallreq_o=1.

Reset (rst=0, asynchronous):
- FSM → IDLE; latched operands and count cleared.
- While asserted, all outputs are 0.
- Reset mid-divide discards the operation; no HI/LO write.

## Timing
- Non-divide ops: zero latency, combinational from the inputs.
- Divide, nonzero divisor: issue cycle (stall), then DW BUSY cycles (stall), then 1 DONE cycle. DONE has no stall and whilo_o=1. Total DW+2 cycles in EX, DW+1 of them stalled.
- Divide by zero: issue cycle (stall), then DONE. 2 cycles.
- A divide presented in the cycle after DONE starts a fresh operation.
- A divide is never issued from DONE, even if the opcode is still present.
- flush_i in the issue cycle prevents the IDLE→BUSY transition.

## Test plan
- Reset release: with rst=0, all outputs are 0. Then OR 0x0000F0F0 | 0x0F0F0000 with alusel LOGIC, wd_i=3, wreg_i=1 → wdata_o=0x0F0FF0F0, wd_o=3, wreg_o=1.
- Shift/compare at DW=32:
  - SRA with reg1_i=4, reg2_i=0x80000000 → 0xF8000000.
  - SLT(−1, 1) → 1.
  - SLTU(0xFFFFFFFF, 1) → 0.
- DIVU 100/7: stallreq_o high for 33 cycles, then DONE with whilo_o=1, lo_o=14, hi_o=2.
- DIV −7/2: lo_o=0xFFFFFFFD (−3), hi_o=0xFFFFFFFF (−1). Also DIV 7/−2: lo_o=−3, hi_o=1.
- DIV 5/0: 1 stall cycle, then DONE with hi_o=5, lo_o=0xFFFFFFFF.
- Cancellation:
  - flush_i at BUSY count 10 → IDLE next cycle, whilo_o never asserted.
  - rst=0 mid-BUSY → immediate IDLE and zero outputs.
  - Repeat both at DW=16 to check the DW+1 stall count (17 cycles).

Source files
------------

// File: rtl/ex_mdu.sv
// ex_mdu: MIPS execute stage. Single-cycle logic/shift/move/arith results,
// plus an iterative restoring divider that stalls the pipeline until the
// HI/LO write is ready. Flush or reset cancels an in-flight divide.
module ex_mdu #(
   parameter  int DW = 32,
   parameter  int AW = 5,
   localparam int SW = $clog2(DW)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    aluop_i,
   input  logic [2:0]    alusel_i,
   input  logic [DW-1:0] reg1_i,
   input  logic [DW-1:0] reg2_i,
   input  logic [AW-1:0] wd_i,
   input  logic          wreg_i,
   input  logic [DW-1:0] hi_i,
   input  logic [DW-1:0] lo_i,
   input  logic          flush_i,
   output logic [AW-1:0] wd_o,
   output logic          wreg_o,
   output logic [DW-1:0] wdata_o,
   output logic          whilo_o,
   output logic [DW-1:0] hi_o,
   output logic [DW-1:0] lo_o,
   output logic          stallreq_o
);

   localparam logic [7:0] OP_AND  = 8'b00100100;
   localparam logic [7:0] OP_OR   = 8'b00100101;
   localparam logic [7:0] OP_XOR  = 8'b00100110;
   localparam logic [7:0] OP_NOR  = 8'b00100111;
   localparam logic [7:0] OP_SLL  = 8'b01111100;
   localparam logic [7:0] OP_SRL  = 8'b00000010;
   localparam logic [7:0] OP_SRA  = 8'b00000011;
   localparam logic [7:0] OP_ADDU = 8'b00100001;
   localparam logic [7:0] OP_SUBU = 8'b00100011;
   localparam logic [7:0] OP_SLT  = 8'b00101010;
   localparam logic [7:0] OP_SLTU = 8'b00101011;
   localparam logic [7:0] OP_MFHI = 8'b00010000;
   localparam logic [7:0] OP_MFLO = 8'b00010010;
   localparam logic [7:0] OP_DIV  = 8'b00011010;
   localparam logic [7:0] OP_DIVU = 8'b00011011;

   localparam logic [2:0] SEL_LOGIC = 3'b001;
   localparam logic [2:0] SEL_SHIFT = 3'b010;
   localparam logic [2:0] SEL_MOVE  = 3'b011;
   localparam logic [2:0] SEL_ARITH = 3'b100;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   // Two's-complement magnitude when the operand is treated as signed.
   function automatic logic [DW-1:0] mag(input logic [DW-1:0] v, input logic is_signed);
      return (is_signed && v[DW-1]) ? -v : v;
   endfunction

   // Restore the sign of an unsigned divider result.
   function automatic logic [DW-1:0] apply_sign(input logic [DW-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   state_t               state, state_nxt;
   logic [SW-1:0]        cnt;
   logic [DW-1:0]        dvd, dvs, rem, res_hi, res_lo;
   logic                 neg_q, neg_r;
   logic [DW:0]          rem_sh, diff;
   logic [DW-1:0]        step_rem, step_quo;
   logic [DW-1:0]        logic_res, shift_res, move_res, arith_res, alu_res;
   logic signed [DW-1:0] r1_s, r2_s;

   wire [SW-1:0] sh         = reg1_i[SW-1:0];
   wire          is_div     = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
   wire          signed_div = (aluop_i == OP_DIV);
   wire          div_zero   = (reg2_i == '0);
   wire          issue      = (state == S_IDLE) && is_div && !flush_i;
   wire          last       = (cnt == SW'(DW - 1));

   assign r1_s = reg1_i;
   assign r2_s = reg2_i;

   // Single-cycle results per class; unknown opcodes leave their class at zero.
   always_comb begin
      logic_res = '0;
      shift_res = '0;
      move_res  = '0;
      arith_res = '0;
      case (aluop_i)
         OP_AND:  logic_res = reg1_i & reg2_i;
         OP_OR:   logic_res = reg1_i | reg2_i;
         OP_XOR:  logic_res = reg1_i ^ reg2_i;
         OP_NOR:  logic_res = ~(reg1_i | reg2_i);
         OP_SLL:  shift_res = reg2_i << sh;
         OP_SRL:  shift_res = reg2_i >> sh;
         OP_SRA:  shift_res = r2_s >>> sh;
         OP_MFHI: move_res  = hi_i;
         OP_MFLO: move_res  = lo_i;
         OP_ADDU: arith_res = reg1_i + reg2_i;
         OP_SUBU: arith_res = reg1_i - reg2_i;
         OP_SLT:  arith_res = {{(DW-1){1'b0}}, (r1_s < r2_s)};
         OP_SLTU: arith_res = {{(DW-1){1'b0}}, (reg1_i < reg2_i)};
         default: ;
      endcase
      case (alusel_i)
         SEL_LOGIC: alu_res = logic_res;
         SEL_SHIFT: alu_res = shift_res;
         SEL_MOVE:  alu_res = move_res;
         SEL_ARITH: alu_res = arith_res;
         default:   alu_res = '0;
      endcase
   end

   // One restoring step: shift the next dividend bit in, keep the difference if non-negative.
   always_comb begin
      rem_sh = {rem, dvd[DW-1]};
      diff   = rem_sh - {1'b0, dvs};
      if (!diff[DW]) begin
         step_rem = diff[DW-1:0];
         step_quo = {dvd[DW-2:0], 1'b1};
      end else begin
         step_rem = rem_sh[DW-1:0];
         step_quo = {dvd[DW-2:0], 1'b0};
      end
   end

   // Divider state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Divider next-state: flush abandons BUSY/DONE, DONE always returns to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (issue) state_nxt = div_zero ? S_DONE : S_BUSY;
         S_BUSY: begin
            if (flush_i)   state_nxt = S_IDLE;
            else if (last) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Divider datapath: latch magnitudes on issue, iterate in BUSY, capture signed results.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dvd    <= '0;
         dvs    <= '0;
         rem    <= '0;
         cnt    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         res_hi <= '0;
         res_lo <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (issue && div_zero) begin
                  res_hi <= reg1_i;
                  res_lo <= '1;
               end else if (issue) begin
                  dvd   <= mag(reg1_i, signed_div);
                  dvs   <= mag(reg2_i, signed_div);
                  rem   <= '0;
                  cnt   <= '0;
                  neg_q <= signed_div && (reg1_i[DW-1] ^ reg2_i[DW-1]);
                  neg_r <= signed_div && reg1_i[DW-1];
               end
            end
            S_BUSY: begin
               if (!flush_i) begin
                  rem <= step_rem;
                  dvd <= step_quo;
                  cnt <= cnt + SW'(1);
                  if (last) begin
                     res_lo <= apply_sign(step_quo, neg_q);
                     res_hi <= apply_sign(step_rem, neg_r);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs: everything is held at zero while reset is asserted.
   always_comb begin
      wd_o       = '0;
      wreg_o     = 1'b0;
      wdata_o    = '0;
      whilo_o    = 1'b0;
      hi_o       = '0;
      lo_o       = '0;
      stallreq_o = 1'b0;
      if (rst) begin
         wd_o    = wd_i;
         wreg_o  = wreg_i && !is_div;
         wdata_o = alu_res;
         case (state)
            S_IDLE: stallreq_o = issue;
            S_BUSY: stallreq_o = 1'b1;
            S_DONE: begin
               if (!flush_i) begin
                  whilo_o = 1'b1;
                  hi_o    = res_hi;
                  lo_o    = res_lo;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: randomized bench for ex_mdu against a plain-arithmetic reference,
// with a 32-bit and a 16-bit instance for the divider timing checks.
module tb_ex_mdu;

   localparam logic [7:0] OP_AND  = 8'h24, OP_OR   = 8'h25, OP_XOR  = 8'h26, OP_NOR  = 8'h27;
   localparam logic [7:0] OP_SLL  = 8'h7C, OP_SRL  = 8'h02, OP_SRA  = 8'h03;
   localparam logic [7:0] OP_ADDU = 8'h21, OP_SUBU = 8'h23, OP_SLT  = 8'h2A, OP_SLTU = 8'h2B;
   localparam logic [7:0] OP_MFHI = 8'h10, OP_MFLO = 8'h12, OP_DIV  = 8'h1A, OP_DIVU = 8'h1B;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic [7:0]  a_aluop;  logic [2:0] a_sel;  logic [31:0] a_r1, a_r2, a_hi, a_lo;
   logic [4:0]  a_wd;     logic a_wreg, a_flush;
   logic [4:0]  a_wd_o;   logic a_wreg_o, a_whilo, a_stall;
   logic [31:0] a_wdata, a_hio, a_loo;

   logic [7:0]  b_aluop;  logic [2:0] b_sel;  logic [15:0] b_r1, b_r2, b_hi, b_lo;
   logic [4:0]  b_wd;     logic b_wreg, b_flush;
   logic [4:0]  b_wd_o;   logic b_wreg_o, b_whilo, b_stall;
   logic [15:0] b_wdata, b_hio, b_loo;

   ex_mdu #(.DW(32), .AW(5)) u_a (
      .clk(clk), .rst(rst), .aluop_i(a_aluop), .alusel_i(a_sel), .reg1_i(a_r1), .reg2_i(a_r2),
      .wd_i(a_wd), .wreg_i(a_wreg), .hi_i(a_hi), .lo_i(a_lo), .flush_i(a_flush),
      .wd_o(a_wd_o), .wreg_o(a_wreg_o), .wdata_o(a_wdata), .whilo_o(a_whilo),
      .hi_o(a_hio), .lo_o(a_loo), .stallreq_o(a_stall));

   ex_mdu #(.DW(16), .AW(5)) u_b (
      .clk(clk), .rst(rst), .aluop_i(b_aluop), .alusel_i(b_sel), .reg1_i(b_r1), .reg2_i(b_r2),
      .wd_i(b_wd), .wreg_i(b_wreg), .hi_i(b_hi), .lo_i(b_lo), .flush_i(b_flush),
      .wd_o(b_wd_o), .wreg_o(b_wreg_o), .wdata_o(b_wdata), .whilo_o(b_whilo),
      .hi_o(b_hio), .lo_o(b_loo), .stallreq_o(b_stall));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
   endtask

   // Reference ALU: result by opcode, kept only when the opcode belongs to the selected class.
   function automatic logic [31:0] alu_ref(input logic [7:0] op, input logic [2:0] sel,
                                           input logic [31:0] x, y, h, l);
      int          cls;
      logic [31:0] r;
      cls = -1;
      r   = 0;
      case (op)
         OP_AND:  begin cls = 1; r = x & y;    end
         OP_OR:   begin cls = 1; r = x | y;    end
         OP_XOR:  begin cls = 1; r = x ^ y;    end
         OP_NOR:  begin cls = 1; r = ~(x | y); end
         OP_SLL:  begin cls = 2; r = y << x[4:0]; end
         OP_SRL:  begin cls = 2; r = y >> x[4:0]; end
         OP_SRA:  begin cls = 2; r = 32'($signed(y) >>> x[4:0]); end
         OP_MFHI: begin cls = 3; r = h; end
         OP_MFLO: begin cls = 3; r = l; end
         OP_ADDU: begin cls = 4; r = x + y; end
         OP_SUBU: begin cls = 4; r = x - y; end
         OP_SLT:  begin cls = 4; r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0; end
         OP_SLTU: begin cls = 4; r = (x < y) ? 32'd1 : 32'd0; end
         default: cls = -1;
      endcase
      return (cls == int'(sel)) ? r : 32'd0;
   endfunction

   // Reference divide in 64-bit integers (truncating quotient, remainder follows dividend).
   function automatic logic [63:0] div_ref(input logic [7:0] op, input logic [31:0] x, y, input int w);
      logic [31:0] mask, qm, rm;
      longint      sx, sy, q, r, m;
      mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      x = x & mask;
      y = y & mask;
      if (y == 0) return {x, mask};
      m  = longint'(1) << w;
      sx = 0; sx = x;
      sy = 0; sy = y;
      if (op == OP_DIV) begin
         if (x[w-1]) sx = sx - m;
         if (y[w-1]) sy = sy - m;
      end
      q  = sx / sy;
      r  = sx % sy;
      qm = 32'(q) & mask;
      rm = 32'(r) & mask;
      return {rm, qm};
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic drv(input bit b, input logic [7:0] op, input logic [31:0] x, y, input logic fl);
      if (b) begin
         b_aluop = op; b_sel = 3'b000; b_r1 = x[15:0]; b_r2 = y[15:0]; b_wreg = 1'b1; b_flush = fl;
      end else begin
         a_aluop = op; a_sel = 3'b000; a_r1 = x; a_r2 = y; a_wreg = 1'b1; a_flush = fl;
      end
   endtask

   function automatic logic stall_of(input bit b);  return b ? b_stall : a_stall;   endfunction
   function automatic logic whilo_of(input bit b);  return b ? b_whilo : a_whilo;   endfunction
   function automatic logic wreg_of(input bit b);   return b ? b_wreg_o : a_wreg_o; endfunction
   function automatic logic [63:0] hilo_of(input bit b);
      return b ? {16'h0, b_hio, 16'h0, b_loo} : {a_hio, a_loo};
   endfunction
   function automatic logic outs_any(input bit b);
      return b ? |{b_wd_o, b_wreg_o, b_wdata, b_whilo, b_hio, b_loo, b_stall}
               : |{a_wd_o, a_wreg_o, a_wdata, a_whilo, a_hio, a_loo, a_stall};
   endfunction

   // Issue a divide (or continue with the one still presented), count stalls, check the DONE cycle.
   task automatic run_div(input bit b, input logic [7:0] op, input logic [31:0] x, y,
                          input string tag, input bit cont, input bit hold);
      int          w, stalls, early;
      logic [31:0] ym;
      logic [63:0] exp;
      w   = b ? 16 : 32;
      ym  = b ? {16'h0, y[15:0]} : y;
      exp = div_ref(op, x, y, w);
      @(negedge clk);
      if (!cont) drv(b, op, x, y, 1'b0);
      #1;
      stalls = 0;
      early  = 0;
      while (stall_of(b) && stalls < 100) begin
         stalls++;
         if (whilo_of(b)) early++;
         @(negedge clk);
         #1;
      end
      check_eq({tag, "_stalls"}, stalls, (ym == 0) ? 1 : w + 1);
      check_eq({tag, "_early"}, early, 0);
      check_eq({tag, "_whilo"}, whilo_of(b), 1);
      check_eq({tag, "_hilo"}, hilo_of(b), exp);
      check_eq({tag, "_wreg"}, wreg_of(b), 0);
      if (!hold) begin
         @(negedge clk);
         drv(b, 8'h00, 0, 0, 1'b0);
      end
   endtask

   task automatic quiet(input bit b, input string tag);
      int bad;
      bad = 0;
      repeat (40) begin
         if (whilo_of(b) || stall_of(b)) bad++;
         @(negedge clk);
         #1;
      end
      check_eq({tag, "_quiet"}, bad, 0);
   endtask

   // Flush at BUSY count 10: the divider must drop back to IDLE with no HI/LO write.
   task automatic flush_test(input bit b, input string tag);
      @(negedge clk);
      drv(b, OP_DIVU, 100, 7, 1'b0);
      repeat (11) @(negedge clk);
      drv(b, OP_DIVU, 100, 7, 1'b1);
      #1;
      check_eq({tag, "_busy10"}, stall_of(b), 1);
      check_eq({tag, "_nowrite"}, whilo_of(b), 0);
      @(negedge clk);
      drv(b, 8'h00, 0, 0, 1'b0);
      #1;
      check_eq({tag, "_idle"}, stall_of(b), 0);
      quiet(b, tag);
   endtask

   task automatic reset_test(input bit b, input string tag);
      @(negedge clk);
      drv(b, OP_DIVU, 1000, 3, 1'b0);
      repeat (6) @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq({tag, "_zero"}, {outs_any(0), outs_any(1)}, 0);
      @(negedge clk);
      drv(b, 8'h00, 0, 0, 1'b0);
      rst = 1'b1;
      #1;
      check_eq({tag, "_idle"}, stall_of(b), 0);
      quiet(b, tag);
   endtask

   logic [7:0] ops [13] = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA,
                            OP_ADDU, OP_SUBU, OP_SLT, OP_SLTU, OP_MFHI, OP_MFLO};
   logic [2:0] cls [13] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2,
                            3'd4, 3'd4, 3'd4, 3'd4, 3'd3, 3'd3};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      a_aluop = OP_OR; a_sel = 3'b001; a_r1 = 32'h0000_F0F0; a_r2 = 32'h0F0F_0000;
      a_wd = 5'd3; a_wreg = 1'b1; a_hi = '0; a_lo = '0; a_flush = 1'b0;
      b_aluop = '0; b_sel = '0; b_r1 = '0; b_r2 = '0; b_wd = 5'd7; b_wreg = 1'b1;
      b_hi = '0; b_lo = '0; b_flush = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_zero_a", outs_any(0), 0);
      check_eq("rst_zero_b", outs_any(1), 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("or_wdata", a_wdata, 32'h0F0F_F0F0);
      check_eq("or_wd", a_wd_o, 3);
      check_eq("or_wreg", a_wreg_o, 1);

      @(negedge clk);
      a_aluop = OP_SRA; a_sel = 3'b010; a_r1 = 4; a_r2 = 32'h8000_0000;
      #1 check_eq("sra", a_wdata, 32'hF800_0000);
      a_aluop = OP_SLT; a_sel = 3'b100; a_r1 = 32'hFFFF_FFFF; a_r2 = 1;
      #1 check_eq("slt", a_wdata, 1);
      a_aluop = OP_SLTU;
      #1 check_eq("sltu", a_wdata, 0);

      for (int i = 0; i < 150; i++) begin
         int          k;
         logic [7:0]  op;
         logic [2:0]  sel;
         k = $urandom_range(0, 13);
         if (k == 13) begin
            op  = 8'($urandom);
            if (op == OP_DIV || op == OP_DIVU) op = 8'hFF;
            sel = 3'($urandom);
         end else begin
            op  = ops[k];
            sel = ($urandom_range(0, 3) == 0) ? 3'($urandom) : cls[k];
         end
         @(negedge clk);
         a_aluop = op; a_sel = sel; a_r1 = pick(); a_r2 = pick();
         a_hi = $urandom; a_lo = $urandom; a_wd = 5'($urandom); a_wreg = 1'($urandom);
         #1;
         check_eq($sformatf("alu%0d_op%02h_sel%0d", i, op, sel), a_wdata,
                  alu_ref(op, sel, a_r1, a_r2, a_hi, a_lo));
         check_eq($sformatf("alu%0d_wd", i), {a_wd_o, a_wreg_o}, {a_wd, a_wreg});
         check_eq($sformatf("alu%0d_stall", i), {a_stall, a_whilo}, 0);
      end
      @(negedge clk);
      drv(0, 8'h00, 0, 0, 1'b0);

      run_div(0, OP_DIVU, 100, 7, "divu_100_7", 0, 1);
      run_div(0, OP_DIVU, 100, 7, "divu_again", 1, 0);
      run_div(0, OP_DIV, 32'hFFFF_FFF9, 2, "div_m7_2", 0, 0);
      run_div(0, OP_DIV, 7, 32'hFFFF_FFFE, "div_7_m2", 0, 0);
      run_div(0, OP_DIV, 5, 0, "div_5_0", 0, 0);
      check_eq("div_m7_2_const", div_ref(OP_DIV, 32'hFFFF_FFF9, 2, 32), 64'hFFFF_FFFF_FFFF_FFFD);
      for (int i = 0; i < 12; i++) begin
         logic [7:0]  op;
         logic [31:0] x, y;
         op = $urandom_range(0, 1) ? OP_DIV : OP_DIVU;
         x  = pick();
         case ($urandom_range(0, 3))
            0:       y = 0;
            1:       y = $urandom_range(1, 20);
            default: y = pick();
         endcase
         run_div(0, op, x, y, $sformatf("rdiv%0d", i), 0, 0);
      end
      flush_test(0, "flush_a");
      reset_test(0, "reset_a");

      run_div(1, OP_DIVU, 100, 7, "divu16", 0, 0);
      run_div(1, OP_DIV, 32'hFFF9, 2, "div16_m7_2", 0, 0);
      run_div(1, OP_DIV, 5, 0, "div16_5_0", 0, 0);
      flush_test(1, "flush_b");
      reset_test(1, "reset_b");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
